fft_sample_framer: RTL and testbench



---
 rtl/fft_pkg.sv | 10 +
 rtl/fft_pingpong_bank.sv | 46 ++++
 rtl/fft_sample_framer.sv | 78 +++++++
 tb/tb_fft_sample_framer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared word width, framer FSM states and timeout counter sizing
// Contents: WIDTH (sample/FFT word width), FRAME_LEN (samples per frame),
//   FRAMER_TIMEOUT (default F_WAIT limit), FRAMER_TIMEOUT_W, framer_state_t
package fft_pkg;
  localparam int WIDTH = 16;
  localparam int FRAME_LEN = 4;
  localparam int FRAMER_TIMEOUT = 15;
  localparam int FRAMER_TIMEOUT_W = $clog2(FRAMER_TIMEOUT + 1);
  typedef enum logic [1:0] {F_IDLE, F_START, F_WAIT, F_CLEAR} framer_state_t;
endpackage

// File: rtl/fft_pingpong_bank.sv
// fft_pingpong_bank: two 4-sample banks filled in turn, with full flags and a read port
// Ports: clk, rst_n (sync, active-low); s_data/s_valid/s_ready intake handshake;
//   rd_bank selects the read bank, rd_free releases it, rd_full/rd_data show its state
module fft_pingpong_bank #(
  parameter int WIDTH = fft_pkg::WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [WIDTH-1:0]                        s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic                                    rd_bank,
  input  logic                                    rd_free,
  output logic                                    rd_full,
  output logic [fft_pkg::FRAME_LEN-1:0][WIDTH-1:0] rd_data
);
  import fft_pkg::*;
  logic [1:0][FRAME_LEN-1:0][WIDTH-1:0] bank;
  logic [1:0] full, full_nxt;
  logic       wr_bank, wr_bank_nxt, accept, last;
  logic [1:0] wr_ptr;
  // a fill completion and a release never target the same bank, so set and clear compose freely
  always_comb begin
    accept      = s_valid & s_ready;
    last        = accept & (wr_ptr == 2'd3);
    wr_bank_nxt = wr_bank ^ last;
    full_nxt    = (full | ({1'b0, last} << wr_bank)) & ~({1'b0, rd_free} << rd_bank);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank    <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      s_ready <= 1'b1;
    end else begin
      if (accept) bank[wr_bank][wr_ptr] <= s_data;
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      wr_ptr  <= wr_ptr + {1'b0, accept};
      s_ready <= ~full_nxt[wr_bank_nxt];
    end
  end
  assign rd_full = full[rd_bank];
  assign rd_data = bank[rd_bank];
endmodule

// File: rtl/fft_sample_framer.sv
// fft_sample_framer: packs a sample stream into 4-sample ping-pong frames and sequences the FFT core
// Ports: clk, rst_n (sync, active-low); s_data/s_valid/s_ready sample intake;
//   fft_in frame to FFT ([k] = k-th sample of frame), fft_start one-cycle start,
//   fft_clr active-high clear to FFT, fft_valid FFT result level;
//   frame_cnt completed frames (wraps), err_timeout sticky timeout flag
// Option: define FFT_FRAMER_HANN_WINDOW_EN to apply a periodic 4-point Hann window to fft_in
module fft_sample_framer #(
  parameter int WIDTH   = fft_pkg::WIDTH,
  parameter int N_PTS   = 4,
  parameter int TIMEOUT = fft_pkg::FRAMER_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [N_PTS-1:0][WIDTH-1:0] fft_in,
  output logic                        fft_start,
  output logic                        fft_clr,
  input  logic                        fft_valid,
  output logic [15:0]                 frame_cnt,
  output logic                        err_timeout
);
  import fft_pkg::*;
  if (N_PTS != FRAME_LEN || TIMEOUT < 1 || TIMEOUT >= 2 ** FRAMER_TIMEOUT_W) begin : g_bad_cfg
    $error("fft_sample_framer: N_PTS must be 4 and TIMEOUT must fit the wait counter");
  end
  framer_state_t state, next;
  logic rd_bank, rd_full, clr_hold, timeout;
  logic [FRAMER_TIMEOUT_W-1:0] wait_cnt;
  logic [FRAME_LEN-1:0][WIDTH-1:0] raw;
  fft_pingpong_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .rd_bank (rd_bank),
    .rd_free (state == F_CLEAR),
    .rd_full (rd_full),
    .rd_data (raw)
  );
  // a valid in the same cycle as the limit counts as a completion, not a timeout
  assign timeout = (state == F_WAIT) && !fft_valid && (wait_cnt == FRAMER_TIMEOUT_W'(TIMEOUT - 1));
  assign next = state == F_IDLE  ? (rd_full ? F_START : F_IDLE) :
                state == F_START ? F_WAIT :
                state == F_WAIT  ? ((fft_valid || timeout) ? F_CLEAR : F_WAIT) : F_IDLE;
  // clr_hold keeps the FFT core cleared for one extra edge after our own reset lifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= F_IDLE;
      fft_start   <= 1'b0;
      fft_clr     <= 1'b1;
      clr_hold    <= 1'b1;
      rd_bank     <= 1'b0;
      wait_cnt    <= '0;
      frame_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= next;
      fft_start   <= next == F_START;
      fft_clr     <= clr_hold | (next == F_CLEAR);
      clr_hold    <= 1'b0;
      rd_bank     <= rd_bank ^ (state == F_CLEAR);
      wait_cnt    <= state == F_WAIT ? wait_cnt + FRAMER_TIMEOUT_W'(1) : '0;
      frame_cnt   <= frame_cnt + 16'(state == F_WAIT && fft_valid);
      err_timeout <= err_timeout | timeout;
    end
  end
`ifdef FFT_FRAMER_HANN_WINDOW_EN
  assign fft_in[0] = '0;
  assign fft_in[1] = $signed(raw[1]) >>> 1;
  assign fft_in[2] = raw[2];
  assign fft_in[3] = $signed(raw[3]) >>> 1;
`else
  assign fft_in = raw;
`endif
endmodule

// File: tb/tb_fft_sample_framer.sv
// tb_fft_sample_framer: scoreboard bench for fft_sample_framer with a behavioural FFT neighbour
module tb_fft_sample_framer;
  localparam int W = 16;
  typedef logic [3:0][W-1:0] frame_t;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, fft_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, fft_start, fft_clr, err_timeout;
  frame_t fft_in, last_in, e;
  logic [15:0] frame_cnt;
  int tests = 0, fails = 0, cyc = 0, start_cyc = -1, clr_cyc = -1, fcnt = 0;
  bit fft_on = 1'b1;
  frame_t exp_q[$];

  fft_sample_framer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fft_in(fft_in), .fft_start(fft_start), .fft_clr(fft_clr), .fft_valid(fft_valid),
    .frame_cnt(frame_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic frame_t win(input frame_t f);
    win = f;
`ifdef FFT_FRAMER_HANN_WINDOW_EN
    win[0] = '0;
    win[1] = $signed(f[1]) >>> 1;
    win[3] = $signed(f[3]) >>> 1;
`endif
  endfunction

  // FFT neighbour: valid rises 3 cycles after start (when fft_on), drops on clear; scoreboard pops on start
  initial forever begin
    @(negedge clk);
    if (!rst_n || fft_clr) begin
      fft_valid = 1'b0;
      fcnt = 0;
    end else if (fft_start) fcnt = 1;
    else if (fcnt > 0) begin
      fcnt++;
      if (fcnt == 4 && fft_on) fft_valid = 1'b1;
    end
    if (rst_n && fft_clr) clr_cyc = cyc;
    if (rst_n && fft_start) begin
      start_cyc = cyc;
      last_in = fft_in;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL frame_data: start with fft_in=%h, required no frame pending", fft_in);
      end else begin
        e = exp_q.pop_front();
        if (fft_in !== e) begin
          fails++;
          $display("FAIL frame_data: fft_in=%h required %h", fft_in, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] v, input bit gap, output int acc);
    int waited = 0;
    @(negedge clk);
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_data = v;
    s_valid = 1'b1;
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (!s_ready) begin
      fails++;
      $display("FAIL accept: s_ready=%b after %0d cycles, required 1", s_ready, waited);
    end
    acc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit rnd, output int acc);
    exp_q.push_back(win(f));
    for (int k = 0; k < 4; k++) send(f[k], rnd ? 1'($urandom_range(1)) : 1'b0, acc);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int limit);
    int n = 0;
    while (frame_cnt !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (frame_cnt !== target) begin
      fails++;
      $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({fft_clr, fft_start, s_ready, err_timeout} !== 4'b1010 || frame_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: clr/start/ready/err=%b cnt=%0d, required 1010 cnt=0",
               {fft_clr, fft_start, s_ready, err_timeout}, frame_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (fft_clr !== 1'b1) begin
      fails++;
      $display("FAIL clr_hold: fft_clr=%b, required 1", fft_clr);
    end
    @(negedge clk);
    tests++;
    if (fft_clr !== 1'b0) begin
      fails++;
      $display("FAIL clr_release: fft_clr=%b, required 0", fft_clr);
    end
  endtask

  task automatic test_single();
    frame_t f;
    int t;
    f[0] = 16'd100; f[1] = 16'd200; f[2] = 16'd300; f[3] = 16'd400;
    start_cyc = -1;
    clr_cyc = -1;
    send_frame(f, 1'b0, t);
    idle();
    wait_cnt(16'd1, 50);
    @(negedge clk);
    tests++;
    if (start_cyc !== t + 2) begin
      fails++;
      $display("FAIL start_latency: start cycle %0d, required %0d", start_cyc, t + 2);
    end
    tests++;
    if (clr_cyc !== start_cyc + 4) begin
      fails++;
      $display("FAIL clr_latency: clr cycle %0d, required %0d", clr_cyc, start_cyc + 4);
    end
  endtask

  task automatic test_timeout();
    frame_t f;
    int acc;
    do_reset(2);
    fft_on = 1'b0;
    clr_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin
        for (int k = 0; k < 4; k++) f[k] = 16'(i + k + 1);
        exp_q.push_back(win(f));
      end
      send(16'(i + 1), 1'b0, acc);
      if (i == 7) begin
        tests++;
        if (s_ready !== 1'b0) begin
          fails++;
          $display("FAIL ready_drop: s_ready=%b after 8th sample, required 0", s_ready);
        end
      end
      if (i == 8) begin
        tests++;
        if (acc !== clr_cyc + 1) begin
          fails++;
          $display("FAIL resume_cycle: 9th accepted in cycle %0d, required %0d", acc, clr_cyc + 1);
        end
        tests++;
        if (err_timeout !== 1'b1 || frame_cnt !== 16'd0) begin
          fails++;
          $display("FAIL timeout_flag: err=%b cnt=%0d, required err=1 cnt=0", err_timeout, frame_cnt);
        end
      end
    end
    idle();
    repeat (60) @(negedge clk);
    tests++;
    if (err_timeout !== 1'b1 || frame_cnt !== 16'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_drain: err=%b cnt=%0d pending=%0d, required err=1 cnt=0 pending=0",
               err_timeout, frame_cnt, exp_q.size());
    end
    fft_on = 1'b1;
  endtask

  task automatic test_window();
    frame_t f, ew;
    int t;
    do_reset(2);
    f[0] = 16'hFF9C; f[1] = 16'hFFFD; f[2] = 16'd7; f[3] = 16'h7FFF;
`ifdef FFT_FRAMER_HANN_WINDOW_EN
    ew[0] = 16'd0; ew[1] = 16'hFFFE; ew[2] = 16'd7; ew[3] = 16'h3FFF;
`else
    ew = f;
`endif
    send_frame(f, 1'b0, t);
    idle();
    wait_cnt(16'd1, 50);
    tests++;
    if (last_in !== ew) begin
      fails++;
      $display("FAIL window: fft_in=%h required %h", last_in, ew);
    end
  endtask

  task automatic test_back_to_back();
    frame_t f;
    int t;
    do_reset(2);
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 4; k++) f[k] = 16'($urandom_range(65535));
      send_frame(f, 1'b1, t);
    end
    idle();
    wait_cnt(16'd20, 400);
    tests++;
    if (exp_q.size() != 0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain: pending=%0d err=%b, required pending=0 err=0", exp_q.size(), err_timeout);
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    int t, n;
    do_reset(2);
    fft_on = 1'b0;
    start_cyc = -1;
    for (int k = 0; k < 4; k++) f[k] = 16'(1000 + k);
    send_frame(f, 1'b0, t);
    send(16'd2000, 1'b0, t);
    send(16'd2001, 1'b0, t);
    idle();
    n = 0;
    while (start_cyc < 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({fft_clr, fft_start, s_ready, err_timeout} !== 4'b1010 || frame_cnt !== 16'd0) begin
      fails++;
      $display("FAIL midframe_reset: clr/start/ready/err=%b cnt=%0d, required 1010 cnt=0",
               {fft_clr, fft_start, s_ready, err_timeout}, frame_cnt);
    end
    exp_q.delete();
    rst_n = 1'b1;
    fft_on = 1'b1;
    for (int k = 0; k < 4; k++) f[k] = 16'(3000 + 7 * k);
    send_frame(f, 1'b0, t);
    idle();
    wait_cnt(16'd1, 50);
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_window();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
